// File: rtl/forth_pkg.sv
// Shared encodings for the two-stack Forth core: instruction fields, opcode
// selectors, fault codes and the control FSM states.
package forth_pkg;

    localparam logic [15:0] OP_NOP = 16'hE040;

    localparam int B_LIT     = 15;
    localparam int B_CALL    = 12;
    localparam int B_RET     = 12;
    localparam int B_MEM     = 11;
    localparam int B_WE      = 10;
    localparam int B_RSP_DIR = 5;
    localparam int B_RSP_EN  = 4;
    localparam int B_PSP_DIR = 3;
    localparam int B_PSP_EN  = 2;

    typedef enum logic [1:0] {IP_JMP, IP_ZBR, IP_EXEC, IP_ALU} ipsel_e;
    typedef enum logic [1:0] {TS_ALU, TS_KEEP, TS_PSTK, TS_RSTK} tos_sel_e;
    typedef enum logic [2:0] {
        ALU_NOT, ALU_ASHR, ALU_ZEQ, ALU_NEG, ALU_AND, ALU_OR, ALU_XOR, ALU_ADD
    } alu_e;
    typedef enum logic [2:0] {F_NONE, F_POVF, F_PUNF, F_ROVF, F_RUNF} fault_e;
    typedef enum logic [1:0] {S_WAIT, S_RUN, S_MEM, S_HALT} state_e;

endpackage

// File: rtl/forth_stack.sv
// LIFO used for both the parameter and return stacks; the top-of-stack
// register lives in the core, so this holds only the entries below it.
module forth_stack
    import forth_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sp, tidx;

    assign sp    = depth[AW-1:0];
    assign tidx  = sp - 1'b1;
    assign top   = mem[tidx];
    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge clk) begin
        if (reset)
            depth <= '0;
        else if (push && !pop)
            depth <= depth + 1'b1;
        else if (pop && !push)
            depth <= depth - 1'b1;
    end

    // push+pop replaces the current top in place
    always_ff @(posedge clk) begin
        if (push && !pop)
            mem[sp] <= din;
        else if (push && pop)
            mem[tidx] <= din;
    end

endmodule

// File: rtl/forth_core_p.sv
// Two-stack Forth CPU with TOS in a register, a stalling data-memory port
// and stack-fault halt. iaddr is the next IP so the sync ROM keeps 1 instr/cycle.
module forth_core_p
    import forth_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 32,
    parameter int IADDR_W     = 12,
    parameter int DADDR_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IADDR_W-1:0] iaddr,
    input  logic [15:0]        idata,
    output logic [DADDR_W-1:0] daddr,
    output logic [WIDTH-1:0]   dwdata,
    input  logic [WIDTH-1:0]   drdata,
    output logic               dreq,
    output logic               dwe,
    input  logic               dack,
    output logic               halted,
    output logic [2:0]         fault
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    state_e             state;
    fault_e             flt;
    logic [IADDR_W-1:0] ip, ip_n, ip_inc;
    logic [WIDTH-1:0]   tos, tos_n, alu, p_top, r_top, r_din;
    logic [15:0]        ins, mem_ir;
    logic [DW-1:0]      p_depth, r_depth;
    logic               p_full, p_empty, r_full, r_empty;
    logic               p_push, p_pop, r_push, r_pop, is_mem, commit;
    logic               unused_bits;

    assign unused_bits = ^ins[9:8];

    // A held mem op re-decodes from its latched copy; WAIT/HALT see a NOP.
    always_comb begin
        case (state)
            S_RUN:   ins = idata;
            S_MEM:   ins = mem_ir;
            default: ins = OP_NOP;
        endcase
    end

    always_comb begin
        case (alu_e'(ins[2:0]))
            ALU_NOT:  alu = ~tos;
            ALU_ASHR: alu = {tos[WIDTH-1], tos[WIDTH-1:1]};
            ALU_ZEQ:  alu = {WIDTH{tos == '0}};
            ALU_NEG:  alu = -tos;
            ALU_AND:  alu = tos & p_top;
            ALU_OR:   alu = tos | p_top;
            ALU_XOR:  alu = tos ^ p_top;
            default:  alu = tos + p_top;
        endcase
    end

    always_comb begin
        ip_inc = ip + 1'b1;
        ip_n   = ip_inc;
        tos_n  = tos;
        r_din  = {{(WIDTH-IADDR_W){1'b0}}, ip_inc};
        p_push = 1'b0;
        p_pop  = 1'b0;
        r_push = 1'b0;
        r_pop  = 1'b0;
        is_mem = 1'b0;
        if (!ins[B_LIT]) begin
            p_push = 1'b1;
            tos_n  = {{(WIDTH-15){1'b0}}, ins[14:0]};
        end else begin
            case (ipsel_e'(ins[14:13]))
                IP_JMP: begin
                    ip_n   = ins[IADDR_W-1:0];
                    r_push = ins[B_CALL];
                end
                IP_ZBR: begin
                    ip_n  = (tos == '0) ? ins[IADDR_W-1:0] : ip_inc;
                    p_pop = 1'b1;
                    tos_n = p_top;
                end
                IP_EXEC: begin
                    ip_n   = tos[IADDR_W-1:0];
                    r_push = 1'b1;
                    p_pop  = 1'b1;
                    tos_n  = p_top;
                end
                default: begin
                    if (ins[B_MEM]) begin
                        is_mem = 1'b1;
                        if (ins[B_WE]) begin
                            p_pop = 1'b1;
                            tos_n = p_top;
                        end else begin
                            tos_n = drdata;
                        end
                    end else begin
                        case (tos_sel_e'(ins[7:6]))
                            TS_ALU:  tos_n = alu;
                            TS_PSTK: tos_n = p_top;
                            TS_RSTK: tos_n = r_top;
                            default: tos_n = tos;
                        endcase
                        p_push = ins[B_PSP_EN] &  ins[B_PSP_DIR];
                        p_pop  = ins[B_PSP_EN] & ~ins[B_PSP_DIR];
                        r_push = ins[B_RSP_EN] &  ins[B_RSP_DIR];
                        r_pop  = ins[B_RET] | (ins[B_RSP_EN] & ~ins[B_RSP_DIR]);
                        if (ins[B_RSP_EN] && ins[B_RSP_DIR])
                            r_din = tos;
                        if (ins[B_RET])
                            ip_n = r_top[IADDR_W-1:0];
                    end
                end
            endcase
        end
    end

    // P-stack faults take priority over R-stack faults
    always_comb begin
        flt = F_NONE;
        if (p_push && !p_pop && p_full)
            flt = F_POVF;
        else if (p_pop && !p_push && p_empty)
            flt = F_PUNF;
        else if (r_push && !r_pop && r_full)
            flt = F_ROVF;
        else if (r_pop && !r_push && r_empty)
            flt = F_RUNF;
    end

    assign commit = (state == S_RUN && flt == F_NONE && !is_mem) ||
                    (state == S_MEM && dack);
    assign iaddr  = commit ? ip_n : ip;
    assign daddr  = tos[DADDR_W-1:0];
    assign dwdata = p_top;

    forth_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_pstk (
        .clk   (clk),
        .reset (reset),
        .push  (p_push && commit),
        .pop   (p_pop && commit),
        .din   (tos),
        .top   (p_top),
        .depth (p_depth),
        .full  (p_full),
        .empty (p_empty)
    );

    forth_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_rstk (
        .clk   (clk),
        .reset (reset),
        .push  (r_push && commit),
        .pop   (r_pop && commit),
        .din   (r_din),
        .top   (r_top),
        .depth (r_depth),
        .full  (r_full),
        .empty (r_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_WAIT;
            ip     <= '0;
            tos    <= '0;
            mem_ir <= OP_NOP;
            dreq   <= 1'b0;
            dwe    <= 1'b0;
            halted <= 1'b0;
            fault  <= F_NONE;
        end else begin
            case (state)
                S_WAIT: state <= S_RUN;
                S_RUN: begin
                    if (flt != F_NONE) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        fault  <= flt;
                    end else if (is_mem) begin
                        state  <= S_MEM;
                        mem_ir <= ins;
                        dreq   <= 1'b1;
                        dwe    <= ins[B_WE];
                    end
                end
                S_MEM: begin
                    if (dack) begin
                        state <= S_RUN;
                        dreq  <= 1'b0;
                        dwe   <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (commit) begin
                ip  <= ip_n;
                tos <= tos_n;
            end
        end
    end

endmodule

// File: tb/tb_forth_core_p.sv
// Directed bench for forth_core_p: a default instance plus a STACK_DEPTH=4
// instance for the overflow case, each fed by a behavioural sync ROM.
module tb_forth_core_p;
    logic        clk = 1'b0, reset = 1'b1;
    logic [11:0] iaddr, daddr, iaddr2, daddr2;
    logic [15:0] idata, idata2, dwdata, dwdata2, drdata = '0, drdata2 = '0;
    logic        dreq, dwe, dack = 1'b0, halted;
    logic        dreq2, dwe2, dack2 = 1'b0, halted2;
    logic [2:0]  fault, fault2;
    logic [15:0] rom  [4096];
    logic [15:0] rom2 [4096];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        idata  <= rom[iaddr];
        idata2 <= rom2[iaddr2];
    end

    forth_core_p dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .daddr(daddr),
        .dwdata(dwdata), .drdata(drdata), .dreq(dreq), .dwe(dwe), .dack(dack),
        .halted(halted), .fault(fault)
    );

    forth_core_p #(.STACK_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .iaddr(iaddr2), .idata(idata2), .daddr(daddr2),
        .dwdata(dwdata2), .drdata(drdata2), .dreq(dreq2), .dwe(dwe2), .dack(dack2),
        .halted(halted2), .fault(fault2)
    );

    task automatic load_nops;
        for (int i = 0; i < 4096; i++) begin
            rom[i]  = 16'hE040;
            rom2[i] = 16'hE040;
        end
    endtask

    // leaves the bench at a negedge with reset just released (core in WAIT)
    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        load_nops();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (iaddr !== 12'h000) begin n_bad++; $display("FAIL rst_iaddr: got %h want 000", iaddr); end
        n_cmp++; if ({dreq, dwe, halted} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl: got %b want 000", {dreq, dwe, halted}); end
        n_cmp++; if (fault !== 3'd0) begin n_bad++; $display("FAIL rst_fault: got %0d want 0", fault); end
        n_cmp++; if (dut.tos !== 16'h0000) begin n_bad++; $display("FAIL rst_tos: got %h want 0000", dut.tos); end
        n_cmp++; if ({dut.p_depth, dut.r_depth} !== 12'd0) begin n_bad++; $display("FAIL rst_depth: got %0d/%0d want 0/0", dut.p_depth, dut.r_depth); end
        reset = 1'b0;
    endtask

    task automatic test_add;
        load_nops();
        rom[0] = 16'h0005; rom[1] = 16'h0007; rom[2] = 16'hE007;
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if (dut.tos !== 16'd12) begin n_bad++; $display("FAIL add_tos: got %h want 000c", dut.tos); end
        n_cmp++; if (dut.p_depth !== 6'd1) begin n_bad++; $display("FAIL add_pdepth: got %0d want 1", dut.p_depth); end
        n_cmp++; if (dut.p_top !== 16'h0000) begin n_bad++; $display("FAIL add_nos: got %h want 0000", dut.p_top); end
        n_cmp++; if (iaddr !== 12'h004) begin n_bad++; $display("FAIL add_iaddr: got %h want 004", iaddr); end
    endtask

    task automatic test_alu;
        logic [15:0] exp_t [7];
        exp_t = '{16'h0005, 16'hFFFB, 16'hFFFD, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0};
        load_nops();
        rom[0] = 16'h0005; rom[1] = 16'hE003; rom[2] = 16'hE001; rom[3] = 16'hE002;
        rom[4] = 16'hE002; rom[5] = 16'h0F0F; rom[6] = 16'hE006;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_cmp++; if (dut.tos !== exp_t[k]) begin n_bad++; $display("FAIL alu_tos[%0d]: got %h want %h", k, dut.tos, exp_t[k]); end
        end
        n_cmp++; if (dut.p_depth !== 6'd1) begin n_bad++; $display("FAIL alu_pdepth: got %0d want 1", dut.p_depth); end
    endtask

    task automatic test_call_ret;
        load_nops();
        rom[0] = 16'h9020; rom[12'h020] = 16'hF040;
        do_reset();
        @(negedge clk);
        n_cmp++; if (iaddr !== 12'h020) begin n_bad++; $display("FAIL call_iaddr: got %h want 020", iaddr); end
        @(negedge clk);
        n_cmp++; if (iaddr !== 12'h001) begin n_bad++; $display("FAIL ret_iaddr: got %h want 001", iaddr); end
        n_cmp++; if (dut.r_depth !== 6'd1) begin n_bad++; $display("FAIL call_rdepth: got %0d want 1", dut.r_depth); end
        n_cmp++; if (dut.r_top !== 16'h0001) begin n_bad++; $display("FAIL call_rtop: got %h want 0001", dut.r_top); end
        @(negedge clk);
        n_cmp++; if (dut.r_depth !== 6'd0) begin n_bad++; $display("FAIL ret_rdepth: got %0d want 0", dut.r_depth); end
        n_cmp++; if (iaddr !== 12'h002) begin n_bad++; $display("FAIL ret_next: got %h want 002", iaddr); end
    endtask

    task automatic test_rstack_ops;
        load_nops();
        rom[0] = 16'h0011; rom[1] = 16'h0022; rom[2] = 16'hE0B4; rom[3] = 16'hE0DC;
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if ({dut.tos, 6'(dut.p_depth), 6'(dut.r_depth)} !== {16'h0011, 6'd1, 6'd1}) begin
            n_bad++; $display("FAIL tor: got tos=%h p=%0d r=%0d want 0011/1/1", dut.tos, dut.p_depth, dut.r_depth); end
        @(negedge clk);
        n_cmp++; if ({dut.tos, 6'(dut.p_depth), 6'(dut.r_depth)} !== {16'h0022, 6'd2, 6'd0}) begin
            n_bad++; $display("FAIL rfrom: got tos=%h p=%0d r=%0d want 0022/2/0", dut.tos, dut.p_depth, dut.r_depth); end
    endtask

    task automatic test_fetch;
        load_nops();
        rom[0] = 16'h0010; rom[1] = 16'hE800;
        do_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (dreq !== 1'b0) begin n_bad++; $display("FAIL fetch_decode_dreq: got %b want 0", dreq); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({dreq, dwe} !== 2'b10) begin n_bad++; $display("FAIL fetch_req[%0d]: got %b want 10", c, {dreq, dwe}); end
            n_cmp++; if ({iaddr, daddr} !== {12'h001, 12'h010}) begin n_bad++; $display("FAIL fetch_frozen[%0d]: iaddr %h daddr %h want 001 010", c, iaddr, daddr); end
            n_cmp++; if (dut.tos !== 16'h0010) begin n_bad++; $display("FAIL fetch_tos_held[%0d]: got %h want 0010", c, dut.tos); end
        end
        dack = 1'b1; drdata = 16'hBEEF;
        @(negedge clk);
        dack = 1'b0; drdata = '0;
        n_cmp++; if (dut.tos !== 16'hBEEF) begin n_bad++; $display("FAIL fetch_tos: got %h want beef", dut.tos); end
        n_cmp++; if ({dreq, iaddr} !== {1'b0, 12'h003}) begin n_bad++; $display("FAIL fetch_done: dreq %b iaddr %h want 0 003", dreq, iaddr); end
    endtask

    task automatic test_store;
        load_nops();
        rom[0] = 16'h00AB; rom[1] = 16'h0020; rom[2] = 16'hEC00;
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if ({dreq, dwe, daddr, dwdata} !== {2'b11, 12'h020, 16'h00AB}) begin
            n_bad++; $display("FAIL store_req: got %b%b %h %h want 11 020 00ab", dreq, dwe, daddr, dwdata); end
        dack = 1'b1;
        @(negedge clk);
        dack = 1'b0;
        n_cmp++; if ({dut.tos, 6'(dut.p_depth)} !== {16'h00AB, 6'd1}) begin
            n_bad++; $display("FAIL store_pop: got tos=%h p=%0d want 00ab/1", dut.tos, dut.p_depth); end
        n_cmp++; if ({dreq, dwe, iaddr} !== {2'b00, 12'h004}) begin n_bad++; $display("FAIL store_done: got %b %h want 00 004", {dreq, dwe}, iaddr); end
    endtask

    task automatic test_reset_mid_mem;
        load_nops();
        rom[0] = 16'h0010; rom[1] = 16'hE800;
        do_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (dreq !== 1'b1) begin n_bad++; $display("FAIL midmem_req: got %b want 1", dreq); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (dreq !== 1'b0) begin n_bad++; $display("FAIL midmem_drop: got %b want 0", dreq); end
        dack = 1'b1; drdata = 16'h5555; reset = 1'b0;
        @(negedge clk);
        dack = 1'b0; drdata = '0;
        @(negedge clk);
        n_cmp++; if ({dreq, dut.tos} !== {1'b0, 16'h0010}) begin n_bad++; $display("FAIL midmem_late_ack: dreq %b tos %h want 0 0010", dreq, dut.tos); end
    endtask

    task automatic test_underflow;
        load_nops();
        rom[0] = 16'hE084;
        do_reset();
        @(negedge clk);
        n_cmp++; if ({halted, iaddr} !== {1'b0, 12'h000}) begin n_bad++; $display("FAIL unf_decode: halted %b iaddr %h want 0 000", halted, iaddr); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({halted, fault} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL unf_fault: got %b/%0d want 1/2", halted, fault); end
        n_cmp++; if ({iaddr, dut.tos} !== {12'h000, 16'h0000}) begin n_bad++; $display("FAIL unf_frozen: iaddr %h tos %h want 000 0000", iaddr, dut.tos); end
    endtask

    task automatic test_overflow;
        load_nops();
        for (int i = 0; i < 5; i++) rom2[i] = 16'(i + 1);
        do_reset();
        repeat (5) @(negedge clk);
        n_cmp++; if ({halted2, 6'(dut2.p_depth)} !== {1'b0, 6'd4}) begin n_bad++; $display("FAIL ovf_pre: halted %b p=%0d want 0/4", halted2, dut2.p_depth); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({halted2, fault2} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL ovf_fault: got %b/%0d want 1/1", halted2, fault2); end
        n_cmp++; if ({6'(dut2.p_depth), dut2.tos, iaddr2} !== {6'd4, 16'h0004, 12'h004}) begin
            n_bad++; $display("FAIL ovf_frozen: p=%0d tos %h iaddr %h want 4 0004 004", dut2.p_depth, dut2.tos, iaddr2); end
    endtask

    task automatic test_zbranch;
        logic [15:0] cond [2];
        logic [11:0] tgt  [2];
        cond = '{16'h0000, 16'h0003};
        tgt  = '{12'h040, 12'h003};
        for (int k = 0; k < 2; k++) begin
            load_nops();
            rom[0] = 16'h0009; rom[1] = cond[k]; rom[2] = 16'hA040;
            do_reset();
            repeat (3) @(negedge clk);
            n_cmp++; if (iaddr !== tgt[k]) begin n_bad++; $display("FAIL zbr_target[%0d]: got %h want %h", k, iaddr, tgt[k]); end
            @(negedge clk);
            n_cmp++; if ({dut.tos, 6'(dut.p_depth)} !== {16'h0009, 6'd1}) begin
                n_bad++; $display("FAIL zbr_pop[%0d]: tos %h p=%0d want 0009/1", k, dut.tos, dut.p_depth); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_call_ret();
        test_rstack_ops();
        test_fetch();
        test_store();
        test_reset_mid_mem();
        test_underflow();
        test_overflow();
        test_zbranch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
